// File: rtl/reg_pipe.sv
`default_nettype none
// ============================================================================
// Module      : reg_pipe
// Description : DEPTH-stage valid/ready register pipeline with bubble
//               collapse, registered occupancy count and synchronous flush.
//               Each stage holds one valid bit and one data word. A word
//               moves forward whenever the next stage is empty or is itself
//               moving, so gaps close up regardless of downstream ready.
// Ports       : i_clk    - clock, all state updates on the rising edge
//               i_rst    - asynchronous active-high reset
//               i_flush  - synchronous clear of every stage and the count
//               i_valid  - upstream word valid
//               o_ready  - pipeline accepts i_data this cycle
//               i_data   - upstream word
//               o_valid  - o_data holds a valid word
//               i_ready  - downstream accepts o_data this cycle
//               o_data   - last-stage word
//               o_count  - number of occupied stages
// Revision    : 1.0 - initial release
// ============================================================================
module reg_pipe #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 3,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic                  r_v [DEPTH];
  logic [DATA_WIDTH-1:0] r_d [DEPTH];
  logic [c_CNT_W-1:0]    r_count;

  // w_rdy[k]: stage k can take a word at the next edge. Index DEPTH is the
  // downstream consumer, so the chain ripples back from i_ready.
  logic [DEPTH:0]        w_rdy;
  logic                  w_in_xfer;
  logic                  w_out_xfer;

  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_rdy[k] = !r_v[k] || w_rdy[k+1];
    end
  end

  // Reset is folded into o_ready so nothing is accepted while it is held,
  // even though the stage state is already cleared asynchronously.
  assign o_ready    = w_rdy[0] && !i_flush && !i_rst;
  assign w_in_xfer  = i_valid && o_ready;
  assign w_out_xfer = r_v[DEPTH-1] && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_v[k] <= 1'b0;
        r_d[k] <= RST_VAL;
      end
      r_count <= '0;
    end else if (i_flush) begin
      // Any output transfer in this cycle has already been seen downstream;
      // everything still inside is discarded.
      for (int k = 0; k < DEPTH; k++) begin
        r_v[k] <= 1'b0;
        r_d[k] <= RST_VAL;
      end
      r_count <= '0;
    end else begin
      // Stage 0 loads from the input port.
      if (w_in_xfer) begin
        r_v[0] <= 1'b1;
        r_d[0] <= i_data;
      end else if (w_rdy[1]) begin
        // Either already empty or its word moved on without a refill.
        r_v[0] <= 1'b0;
      end

      // Later stages load from their predecessor. Data is only written on a
      // load; a vacated stage keeps its last word with the valid bit low.
      for (int k = 1; k < DEPTH; k++) begin
        if (r_v[k-1] && w_rdy[k]) begin
          r_v[k] <= 1'b1;
          r_d[k] <= r_d[k-1];
        end else if (w_rdy[k+1]) begin
          r_v[k] <= 1'b0;
        end
      end

      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = r_v[DEPTH-1];
  assign o_data  = r_d[DEPTH-1];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 3, number of register stages (>=1).
REQ-003 SHALL have parameter RST_VAL, default 0, DATA_WIDTH-bit value loaded into stage data on reset/flush.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_flush  input  1  synchronous pipeline clear.
REQ-007 SHALL have port i_valid  input  1  upstream data valid.
REQ-008 SHALL have port o_ready  output  1  block can accept i_data this cycle.
REQ-009 SHALL have port i_data  input  DATA_WIDTH  upstream data.
REQ-010 SHALL have port o_valid  output  1  o_data valid.
REQ-011 SHALL have port i_ready  input  1  downstream can accept.
REQ-012 SHALL have port o_data  output  DATA_WIDTH  last-stage data.
REQ-013 SHALL have port o_count  output  $clog2(DEPTH+1)  number of occupied stages.

Function
REQ-014 SHALL hold per stage k (0..DEPTH-1) one valid bit v[k] and one DATA_WIDTH data register d[k].
REQ-015 SHALL compute stage readiness rdy[k] = !v[k] || rdy[k+1], with rdy[DEPTH] = i_ready (combinational chain).
REQ-016 SHALL drive o_ready = rdy[0] && !i_flush && !i_rst.
REQ-017 SHALL accept input (transfer) when i_valid && o_ready; d[0] <= i_data, v[0] <= 1.
REQ-018 SHALL move stage k-1 into stage k when v[k-1] && rdy[k]; a stage vacated without refill SHALL clear its valid bit.
REQ-019 SHALL drive o_valid = v[DEPTH-1] and o_data = d[DEPTH-1]; output transfer occurs when o_valid && i_ready.
REQ-020 SHALL give latency DEPTH cycles from input transfer to o_valid with i_ready held 1, throughput one word per cycle.
REQ-021 SHALL collapse bubbles: a word advances into any empty downstream stage regardless of i_ready.
REQ-022 SHALL keep o_data and o_valid stable while o_valid && !i_ready.
REQ-023 SHALL leave d[k] unchanged when stage k is not loaded (no gating to RST_VAL except reset/flush).
REQ-024 SHALL, when full (o_count = DEPTH) with i_ready = 1 and i_valid = 1, accept and emit in the same cycle; o_count unchanged.
REQ-025 SHALL, when full with i_ready = 0, drive o_ready = 0 and drop no data.
REQ-026 SHALL preserve order; no word lost or duplicated.
REQ-027 SHALL update o_count registered: +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither.
REQ-028 SHALL, on i_flush = 1, at the next edge clear all v[k], set all d[k] to RST_VAL, set o_count to 0; input in the flush cycle is discarded (o_ready = 0).
REQ-029 SHALL treat an output transfer in the flush cycle (o_valid && i_ready) as completed to downstream.

Reset
REQ-030 SHALL, while i_rst = 1 (asynchronously, no clock needed), force all v[k] = 0, all d[k] = RST_VAL, o_count = 0, o_valid = 0, o_data = RST_VAL, o_ready = 0.
REQ-031 SHALL, on reset asserted mid-operation, discard all in-flight words.
REQ-032 SHALL drive o_ready = 1 in the first cycle after i_rst deasserts (pipe empty, i_flush = 0).

Verification (DEPTH=3, DATA_WIDTH=32, RST_VAL=0)
REQ-033 Streaming: i_ready=1, push 0xFFFF0000, 0xFFFF00FF, 0xFFFFFFFF on cycles 0,1,2 -> o_valid with those values on cycles 3,4,5; o_count peaks at 3.
REQ-034 Backpressure: i_ready=0, i_valid=1 with 4 words -> 3 accepted, o_ready=0 on 4th, o_count=3, o_data=first word stable; release i_ready -> 4 words out in order, none duplicated.
REQ-035 Bubble collapse: single word 0xA5A5A5A5, i_ready=0 -> o_valid=1 after 3 cycles, o_ready remains 1, o_count=1.
REQ-036 Full pass-through: full pipe, i_valid=1, i_ready=1 for 5 cycles -> one word in and out per cycle, o_count stays 3.
REQ-037 Flush: full pipe, i_valid=1, i_flush=1 one cycle -> next cycle o_count=0, o_valid=0, o_data=0; flushed-cycle input never appears.
REQ-038 Async reset: assert i_rst between edges with 2 words in flight -> o_valid=0, o_data=0, o_count=0, o_ready=0 immediately; after release o_ready=1 and no stale words emerge.
